updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/counter_pkg.sv | 6 +
 rtl/counter_prescaler.sv | 16 +
 rtl/updown_counter.sv | 60 ++++++
 tb/tb_updown_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: overflow policy type and width limits shared by the up/down counter.
package counter_pkg;
  typedef enum logic {MODE_WRAP, MODE_SAT} mode_e;
  localparam int CNT_MIN_WIDTH = 2;
  localparam int CNT_MAX_WIDTH = 32;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits one tick every PRESCALE enabled cycles; restart discards progress.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_l,
  input  logic en,
  input  logic restart,
  output logic tick
);
  logic [7:0] r_cnt;
  assign tick = en && (r_cnt == 8'(PRESCALE - 1));
  always_ff @(posedge clk)
    if (!rst_l || restart) r_cnt <= '0;
    else if (en) r_cnt <= tick ? '0 : r_cnt + 8'd1;
endmodule

// File: rtl/updown_counter.sv
// updown_counter: wrap/saturate up/down counter with clear, clamped load and terminal-count flag.
// Define UPDOWN_COUNTER_PRESCALER_EN to gate count steps through counter_prescaler.
module updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter mode_e            MODE     = MODE_WRAP,
  parameter int               PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);
  localparam bit SAT = (MODE == MODE_SAT);
  if (WIDTH < CNT_MIN_WIDTH || WIDTH > CNT_MAX_WIDTH || MAX_VAL == '0 ||
      PRESCALE < 1 || PRESCALE > 256) begin : g_bad_params
    $error("updown_counter: illegal parameter set");
  end
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_tick;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst_l   (rst_l),
    .en      (en),
    .restart (clear || load),
    .tick    (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif
  assign tc     = up_dn ? (r_count == MAX_VAL) : (r_count == '0);
  assign w_step = en && w_tick;
  // At the terminal value the step either wraps to the opposite end or holds.
  assign w_next = up_dn ? (tc ? (SAT ? MAX_VAL : '0) : r_count + WIDTH'(1))
                        : (tc ? (SAT ? '0 : MAX_VAL) : r_count - WIDTH'(1));
  assign w_load = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  always_ff @(posedge clk)
    if (!rst_l) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= clear ? '0 : load ? w_load : w_step ? w_next : r_count;
      r_wrap  <= !clear && !load && w_step && tc;
    end
  assign count = r_count;
  assign wrap  = r_wrap;
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: three counter configurations checked every cycle against an arithmetic model.
module tb_updown_counter;
  import counter_pkg::*;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  logic clk = 0, rst_l, en, up_dn, clear, load;
  logic [7:0] lv;
  logic [2:0][7:0] dc;
  logic [2:0] dtc, dw;
  int ncmp = 0, nerr = 0;
  int mc[3], mps[3];
  bit mw[3];
  int mx[3] = '{255, 9, 9};
  bit sat[3] = '{0, 1, 0};
  bit started = 0;
  always #5 clk = ~clk;
  updown_counter #(.WIDTH(8), .MAX_VAL(8'd255), .MODE(MODE_WRAP), .PRESCALE(PS)) u_a (
    .clk(clk), .rst_l(rst_l), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(lv), .count(dc[0]), .tc(dtc[0]), .wrap(dw[0]));
  updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .MODE(MODE_SAT), .PRESCALE(PS)) u_b (
    .clk(clk), .rst_l(rst_l), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(lv), .count(dc[1]), .tc(dtc[1]), .wrap(dw[1]));
  updown_counter #(.WIDTH(8), .MAX_VAL(8'd9), .MODE(MODE_WRAP), .PRESCALE(PS)) u_c (
    .clk(clk), .rst_l(rst_l), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(lv), .count(dc[2]), .tc(dtc[2]), .wrap(dw[2]));
  task automatic chk(string n, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  // Reference: priority reset > clear > load > prescaled step, range 0..max.
  always @(posedge clk) begin
    started = 1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_l || clear) begin
        mc[i] = 0; mps[i] = 0; mw[i] = 0;
      end else if (load) begin
        mc[i] = (int'(lv) > mx[i]) ? mx[i] : int'(lv); mps[i] = 0; mw[i] = 0;
      end else if (en && (mps[i] + 1) % PS == 0) begin
        mps[i] = 0;
        if (up_dn) begin
          mw[i] = (mc[i] == mx[i]);
          mc[i] = mw[i] ? (sat[i] ? mx[i] : 0) : mc[i] + 1;
        end else begin
          mw[i] = (mc[i] == 0);
          mc[i] = mw[i] ? (sat[i] ? 0 : mx[i]) : mc[i] - 1;
        end
      end else begin
        if (en) mps[i] = mps[i] + 1;
        mw[i] = 0;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (started)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("count[%0d]", i), int'(dc[i]), mc[i]);
        chk($sformatf("tc[%0d]", i), int'(dtc[i]), int'(up_dn ? mc[i] == mx[i] : mc[i] == 0));
        chk($sformatf("wrap[%0d]", i), int'(dw[i]), int'(mw[i]));
      end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst_l = 0; en = 0; up_dn = 0; clear = 0; load = 0; lv = 0;
    step(2);
    chk("reset_count", int'(dc[0]), 0);
    chk("reset_tc_down", int'(dtc[0]), 1);
    chk("reset_wrap", int'(dw[0]), 0);
    rst_l = 1; en = 1; up_dn = 1;
`ifdef UPDOWN_COUNTER_PRESCALER_EN
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (k == 3) chk("ps_before_tick", int'(dc[0]), 0);
      if (k == 4) chk("ps_first_tick", int'(dc[0]), 1);
      if (k == 8) chk("ps_second_tick", int'(dc[0]), 2);
    end
    step(2);
    en = 0; step(3);
    en = 1; step(1);
    chk("ps_gap_hold", int'(dc[0]), 2);
    step(1);
    chk("ps_gap_delayed", int'(dc[0]), 3);
`else
    for (int k = 1; k <= 256; k++) begin
      step(1);
      if (k == 12) begin
        chk("sat_hold", int'(dc[1]), 9);
        chk("sat_wrap", int'(dw[1]), 1);
      end
      if (k == 255) begin
        chk("up_255", int'(dc[0]), 255);
        chk("tc_255", int'(dtc[0]), 1);
      end
      if (k == 256) begin
        chk("up_wrap0", int'(dc[0]), 0);
        chk("up_wrap_pulse", int'(dw[0]), 1);
        chk("mod10", int'(dc[2]), 6);
      end
    end
    clear = 1; step(1);
    clear = 0; up_dn = 0; step(1);
    chk("down_wrap9", int'(dc[2]), 9);
    chk("down_wrap9_pulse", int'(dw[2]), 1);
    chk("down_sat0", int'(dc[1]), 0);
    chk("down_sat0_pulse", int'(dw[1]), 1);
    en = 0; load = 1; lv = 200; step(1);
    chk("load_clamp", int'(dc[2]), 9);
    chk("load_200", int'(dc[0]), 200);
    lv = 7; step(1);
    clear = 1; lv = 5; en = 1; step(1);
    chk("clear_beats_load", int'(dc[2]), 0);
    clear = 0; step(1);
    chk("load_beats_step", int'(dc[2]), 5);
    chk("load_no_wrap", int'(dw[2]), 0);
    lv = 100; step(1);
    chk("load_100", int'(dc[0]), 100);
    load = 0; rst_l = 0; up_dn = 1; step(1);
    chk("mid_reset_count", int'(dc[0]), 0);
    chk("mid_reset_wrap", int'(dw[0]), 0);
    rst_l = 1; step(1);
    chk("after_reset_step", int'(dc[0]), 1);
`endif
    for (int k = 0; k < 3000; k++) begin
      rst_l = $urandom_range(0, 49) != 0;
      clear = $urandom_range(0, 29) == 0;
      load  = $urandom_range(0, 19) == 0;
      en    = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      lv = 8'($urandom_range(0, 255));
      step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
